// File: rtl/disp_scan_ctrl_if.sv
// Bundles the data-source side and display-driver side of the scan controller.
// The master drives the scan enable and staged data; the slave (the controller) drives the display.
interface disp_scan_ctrl_if #(
  parameter int unsigned N_DIG = 4
) ();

  logic                 en;
  logic                 load;
  logic [4*N_DIG-1:0]   data_in;
  logic [3:0]           COD;
  logic [N_DIG-1:0]     dig_en;
  logic                 ack;
  logic                 frame;

  modport master (
    output en,
    output load,
    output data_in,
    input  COD,
    input  dig_en,
    input  ack,
    input  frame
  );

  modport slave (
    input  en,
    input  load,
    input  data_in,
    output COD,
    output dig_en,
    output ack,
    output frame
  );

endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed display scan controller.
// Shares one 4-bit code decoder among N_DIG digits: each digit gets a dark blanking window while
// the decoder settles, then a lit dwell. New data is staged in a shadow register and only
// committed to the displayed set at frame boundaries (or while idle), so frames are never torn.
module disp_scan_ctrl #(
  parameter int unsigned N_DIG     = 4,
  parameter int unsigned PRESC     = 1000,
  parameter int unsigned BLANK_CYC = 2,
  parameter bit          BLANK_INV = 1'b1
) (
  input logic             clk,
  input logic             rst,
  disp_scan_ctrl_if.slave bus
);

  localparam int unsigned CntMax = (PRESC > BLANK_CYC) ? PRESC : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = $clog2(N_DIG);
  localparam int unsigned DataW  = 4 * N_DIG;

  localparam logic [CntW-1:0]  PrescLast = CntW'(PRESC - 1);
  localparam logic [CntW-1:0]  BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [IdxW-1:0]  IdxLast   = IdxW'(N_DIG - 1);
  localparam logic [N_DIG-1:0] DigOne    = N_DIG'(1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [3:0]         cod_q, cod_d;
  logic [N_DIG-1:0]   dig_en_q, dig_en_d;
  logic               ack_q, ack_d;
  logic               frame_q, frame_d;
  logic [DataW-1:0]   active_q, active_d;
  logic [DataW-1:0]   shadow_q, shadow_d;
  logic               pending_q, pending_d;

  logic               frame_end;
  logic               enter_blank;
  logic               commit;
  logic [DataW-1:0]   commit_src;

  // Scan sequencing, commit decision and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cod_d       = cod_q;
    dig_en_d    = dig_en_q;
    frame_d     = 1'b0;
    ack_d       = 1'b0;
    active_d    = active_q;
    shadow_d    = bus.load ? bus.data_in : shadow_q;
    pending_d   = pending_q | bus.load;
    frame_end   = 1'b0;
    enter_blank = 1'b0;
    commit      = 1'b0;
    // A load coinciding with a commit goes straight through to the display.
    commit_src  = bus.load ? bus.data_in : shadow_q;

    unique case (state_q)
      StIdle: begin
        dig_en_d = '0;
        if (bus.en) begin
          state_d     = StBlank;
          idx_d       = '0;
          cnt_d       = '0;
          enter_blank = 1'b1;
        end
      end
      StBlank: begin
        dig_en_d = '0;
        if (!bus.en) begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
          // Invalid codes keep their digit dark but still occupy the slot.
          if (BLANK_INV && (cod_q > 4'd9)) begin
            dig_en_d = '0;
          end else begin
            dig_en_d = DigOne << idx_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShow: begin
        if (!bus.en) begin
          state_d  = StIdle;
          idx_d    = '0;
          cnt_d    = '0;
          dig_en_d = '0;
        end else if (cnt_q == PrescLast) begin
          state_d     = StBlank;
          cnt_d       = '0;
          dig_en_d    = '0;
          enter_blank = 1'b1;
          if (idx_q == IdxLast) begin
            idx_d     = '0;
            frame_end = 1'b1;
            frame_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        idx_d    = '0;
        cnt_d    = '0;
        dig_en_d = '0;
      end
    endcase

    commit = (frame_end && (pending_q || bus.load)) || ((state_q == StIdle) && pending_q);
    if (commit) begin
      active_d  = commit_src;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end

    // Present the next digit's code for the whole blanking window so the decoder settles.
    if (enter_blank) begin
      cod_d = active_d[{idx_d, 2'b00} +: 4];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      cod_q     <= '0;
      dig_en_q  <= '0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cod_q     <= cod_d;
      dig_en_q  <= dig_en_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign bus.COD    = cod_q;
  assign bus.dig_en = dig_en_q;
  assign bus.ack    = ack_q;
  assign bus.frame  = frame_q;

endmodule
